byte_packer: RTL and testbench
==============================

// Module: byte_packer
// PURPOSE
//  Assembles a stream of 8-bit bytes into 32-bit words; the inverse of the byte-lane select on the load path.
//  Used on the store/ingress side: bytes arrive one per handshake; a full word is presented with valid/ready.
//  Lane n occupies bits [8n+7:8n], the same lane mapping as the byte select.
//  Flush emits a partial word with a per-lane mask.
// PARAMETERS
//  none (datapath fixed: 8-bit in, 32-bit out, 4 lanes)
// PORTS
//  CLK         in   1   single clock, rising edge
//  RESET_N     in   1   asynchronous reset, active low
//  Byte_In     in   8   incoming byte
//  Byte_Valid  in   1   Byte_In valid
//  Byte_Ready  out  1   packer accepts byte this cycle
//  Flush       in   1   emit current partial word
//  Out_Word    out  32  assembled word
//  Byte_Mask   out  4   bit n = lane n written
//  Word_Valid  out  1   Out_Word/Byte_Mask valid
//  Word_Ready  in   1   consumer takes word this cycle
// BEHAVIOUR
//  Clock and reset: one clock CLK; RESET_N asynchronous, active low.
//  Reset values: Out_Word=0, Byte_Mask=0, Word_Valid=0, lane counter Lane=0, state=FILL.
//    Byte_Ready=1 after reset.
//  Registered outputs: Out_Word, Byte_Mask, Word_Valid.
//    Byte_Ready is combinational: Byte_Ready = (state==FILL).
//  FILL:
//   - Accept on Byte_Valid & Byte_Ready.
//     Lane Lane of Out_Word <= Byte_In; Byte_Mask[Lane] <= 1; Lane <= Lane+1 (2-bit, wraps 3->0).
//   - Accept with Lane==3: next state HOLD, Word_Valid <= 1.
//     Latency is 1 cycle from the 4th accept to Word_Valid.
//   - Flush with Byte_Mask!=0 and no accept: next state HOLD, Word_Valid <= 1 (partial word).
//   - Flush with Byte_Mask==0 and no accept: ignored.
//   - Flush and accept in the same cycle: the byte is written first; next state HOLD.
//     This holds even if Lane<3; the mask includes the new lane.
//  HOLD:
//   - Byte_Ready=0; Out_Word and Byte_Mask are stable while Word_Valid=1 & !Word_Ready.
//   - Flush is ignored.
//   - On Word_Ready: Word_Valid <= 0, Out_Word <= 0, Byte_Mask <= 0, Lane <= 0, state <= FILL.
//   - Unwritten lanes of a partial word always read 0.
//  Throughput: one word per 5 cycles minimum (4 accepts + 1 HOLD handshake); no bypass.
//  Reset mid-operation: asynchronous clear to reset values; a partial word is discarded, not emitted.
//  Word_Valid never drops without Word_Ready (except on reset).
// CONFIGURATION
//  PACKER_BIG_ENDIAN_EN
//   - Defined: arrival order is reversed, the 1st byte goes to [31:24] and the 4th to [7:0].
//     Byte_Mask bit n still refers to bits [8n+7:8n], so the 1st byte sets Byte_Mask[3].
//   - Undefined (default): little-endian; the 1st byte goes to [7:0] and sets Byte_Mask[0].
// TESTING
//  1 Bytes 0x11,0x22,0x33,0x44 back-to-back, Word_Ready=1
//    -> Out_Word=0x44332211, Byte_Mask=4'hF, Word_Valid high 1 cycle.
//  2 Bytes 0xAA,0xBB then Flush
//    -> Out_Word=0x0000BBAA, Byte_Mask=4'h3; the next word starts at lane 0.
//  3 Full word with Word_Ready=0 for 3 cycles
//    -> Out_Word is held, Byte_Ready=0, Byte_Valid is ignored; released on Word_Ready.
//  4 Byte 0x5A with Flush in the same cycle, Lane=0
//    -> Out_Word=0x0000005A, Byte_Mask=4'h1.
//    Flush alone with empty mask -> no Word_Valid.
//  5 RESET_N low after 2 bytes
//    -> all outputs 0 immediately; the next 4 bytes form a clean word starting at lane 0.
//  6 PACKER_BIG_ENDIAN_EN defined, bytes 0x11..0x44
//    -> Out_Word=0x11223344.
//    Partial of 0xAA -> Out_Word=0xAA000000, Byte_Mask=4'h8.

Source files
------------

// File: rtl/byte_packer.sv
// byte_packer: collects a stream of bytes into 32-bit words.
// Each byte arrives on a valid/ready handshake. Each finished word leaves on a
// valid/ready handshake, together with a per-lane mask.
// A flush sends out a partial word. Lanes that were never written read as zero.
// Optional build macro: PACKER_BIG_ENDIAN_EN.
//   Defined:   the first byte of a word lands in bits [31:24].
//   Undefined: the first byte of a word lands in bits [7:0].
// Mask bit n always describes bits [8n+7:8n], whichever byte order is built.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        flush,
  output logic [31:0] out_word,
  output logic [3:0]  byte_mask,
  output logic        word_valid,
  input  logic        word_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  lane_reg, lane_next;
  logic [31:0] word_reg, word_next;
  logic [3:0]  mask_reg, mask_next;
  logic        valid_reg, valid_next;

  logic        accept;
  logic [1:0]  phys_lane;
  logic [3:0]  lane_sel;

  assign byte_ready = (state_reg == FILL);
  assign accept     = byte_valid && (state_reg == FILL);

  // The arrival counter always counts 0..3.
  // The byte order only changes which physical lane that count selects.
`ifdef PACKER_BIG_ENDIAN_EN
  assign phys_lane = 2'd3 - lane_reg;
`else
  assign phys_lane = lane_reg;
`endif

  // Write strobe for each lane: high for the lane that takes the byte accepted this cycle.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_sel
      assign lane_sel[gi] = accept && (phys_lane == 2'(gi));
    end
  endgenerate

  // State, lane counter and output registers; everything clears at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL;
      lane_reg  <= 2'd0;
      word_reg  <= 32'd0;
      mask_reg  <= 4'd0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      word_reg  <= word_next;
      mask_reg  <= mask_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state logic.
  // FILL writes accepted bytes into their lanes and moves to HOLD once the word is full or flushed.
  // HOLD keeps the word steady until the consumer takes it.
  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    word_next  = word_reg;
    mask_next  = mask_reg;
    valid_next = valid_reg;

    unique case (state_reg)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < 4; i++) begin
            if (lane_sel[i]) begin
              word_next[8*i +: 8] = byte_in;
              mask_next[i]        = 1'b1;
            end
          end
          lane_next = lane_reg + 2'd1;
          // A flush in the same cycle as an accept still includes that byte in the word.
          if (lane_reg == 2'd3 || flush) begin
            state_next = HOLD;
            valid_next = 1'b1;
          end
        end else if (flush && mask_reg != 4'd0) begin
          state_next = HOLD;
          valid_next = 1'b1;
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_next = FILL;
          lane_next  = 2'd0;
          word_next  = 32'd0;
          mask_next  = 4'd0;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  assign out_word   = word_reg;
  assign byte_mask  = mask_reg;
  assign word_valid = valid_reg;

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: scoreboard bench for byte_packer.
// The bench predicts each word as it drives the bytes and queues the prediction.
// A monitor removes the oldest prediction and compares it on every word handshake.
module tb_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush;
  logic [31:0] out_word;
  logic [3:0]  byte_mask;
  logic        word_valid;
  logic        word_ready;

  always #5 clk = ~clk;

  byte_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .flush      (flush),
    .out_word   (out_word),
    .byte_mask  (byte_mask),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  typedef struct {
    logic [31:0] word;
    logic [3:0]  mask;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_word = 32'd0;
  logic [3:0]  m_mask = 4'd0;
  int          m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Physical lane of the k-th byte of a word.
  function automatic int lane_of(input int k);
`ifdef PACKER_BIG_ENDIAN_EN
    return 3 - k;
`else
    return k;
`endif
  endfunction

  task automatic model_clear();
    m_word = 32'd0;
    m_mask = 4'd0;
    m_cnt  = 0;
  endtask

  task automatic model_emit();
    exp_t e;
    e.word = m_word;
    e.mask = m_mask;
    sb.push_back(e);
    model_clear();
  endtask

  // Drive one byte, optionally with flush. Hold it until the packer accepts it, then update the model.
  task automatic send_byte(input logic [7:0] b, input logic fl);
    logic rdy;
    bit   ok;
    ok         = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    flush      = fl;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    flush      = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      m_word = m_word | ({24'd0, b} << (8 * lane_of(m_cnt)));
      m_mask = m_mask | 4'(1 << lane_of(m_cnt));
      m_cnt++;
      if (m_cnt == 4 || fl) model_emit();
    end
  endtask

  // Pulse flush for one cycle with no byte.
  task automatic do_flush();
    logic rdy;
    flush = 1'b1;
    @(negedge clk);
    rdy = byte_ready;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (rdy && m_mask != 4'd0) model_emit();
  endtask

  // Wait until every predicted word has been seen, within a fixed cycle budget.
  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare every word handshake against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {31'd0, word_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("word out=%08h mask=%h exp=%08h/%h", out_word, byte_mask, e.word, e.mask);
        chk("word", out_word, e.word);
        chk("mask", {28'd0, byte_mask}, {28'd0, e.mask});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         n;
    rst_n      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b1;
    #12;
    chk("rst_word",  out_word, 32'd0);
    chk("rst_mask",  {28'd0, byte_mask}, 32'd0);
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full word sent back to back. Word_Valid must rise one cycle after the 4th accept.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    chk("latency_valid", {31'd0, word_valid}, 32'd1);
    chk("hold_no_ready", {31'd0, byte_ready}, 32'd0);
    wait_idle();

    // Partial word by flush, then a full word that must start again at lane 0.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_flush();
    wait_idle();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    wait_idle();

    // Consumer stalls. The word must stay steady, and bytes and flush must be ignored.
    word_ready = 1'b0;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b0);
    byte_in    = 8'hEE;
    byte_valid = 1'b1;
    flush      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_word",  out_word, sb[0].word);
      chk("stall_valid", {31'd0, word_valid}, 32'd1);
      chk("stall_ready", {31'd0, byte_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b1;
    wait_idle();

    // A flush with nothing collected must not produce a word.
    do_flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("empty_flush_valid", {31'd0, word_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // A byte and a flush in the same cycle, starting at lane 0.
    send_byte(8'h5A, 1'b1);
    wait_idle();

    // Reset in the middle of a word. The partial word is dropped, and the next word starts clean.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_word",  out_word, 32'd0);
    chk("midrst_mask",  {28'd0, byte_mask}, 32'd0);
    chk("midrst_valid", {31'd0, word_valid}, 32'd0);
    chk("midrst_ready", {31'd0, byte_ready}, 32'd1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'hD4, 1'b0);
    wait_idle();

    // Random words. Each has a random length, a random finishing flush and random consumer stalls.
    for (int w = 0; w < 6; w++) begin
      n = $urandom_range(1, 4);
      word_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        send_byte(b, (k == n - 1 && n < 4) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      if (m_cnt != 0) do_flush();
      @(posedge clk);
      #1;
      word_ready = 1'b1;
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
